countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 26 ++
 rtl/hold_timer.sv | 54 +++++
 rtl/countdown_timer.sv | 137 +++++++++++++
 tb/tb_countdown_timer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : countdown_timer_pkg                                          |
// | Description : Shared definitions for the countdown timer: FSM state        |
// |               encodings (also used by display logic), the default alarm    |
// |               hold length and the hold-counter width.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package countdown_timer_pkg;

    // Encodings are visible on the debug/display 'state' port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    // Number of falling edges the alarm stays asserted (legal 1..255).
    localparam int HOLD_CYC_DEFAULT = 8;

    // Hold counter width; wide enough for the full 1..255 range.
    localparam int HOLD_W = 8;

endpackage : countdown_timer_pkg
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hold_timer                                                   |
// | Description : Counts falling edges while enabled and flags the edge on     |
// |               which HOLD_CYC enabled edges have been seen.                 |
// | Ports       : clk_N   - clock, state changes on falling edge               |
// |               rst     - asynchronous active-low reset                      |
// |               enable  - count this edge                                    |
// |               clear   - restart the count (wins over enable)               |
// |               expired - combinational: the current enabled edge is the     |
// |                         HOLD_CYC-th one                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hold_timer
    import countdown_timer_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEFAULT
) (
    input  logic clk_N,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [HOLD_W-1:0] c_last = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] c_one  = HOLD_W'(1);

    logic [HOLD_W-1:0] count_q;
    logic [HOLD_W-1:0] count_d;

    // count_q holds how many enabled edges have already passed, so the
    // HOLD_CYC-th edge is the one that sees HOLD_CYC-1.
    assign expired = enable && (count_q == c_last);

    always_comb begin
        count_d = count_q;
        if (clear || expired) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + c_one;
        end
    end

    always_ff @(negedge clk_N or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : hold_timer
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : countdown_timer                                              |
// | Description : Loadable down-counter with start/pause control, a one-cycle  |
// |               terminal-count pulse and a timed alarm. All state updates    |
// |               happen on the falling edge of clk_N.                         |
// | Ports       : clk_N   - clock (falling-edge active)                        |
// |               rst     - asynchronous active-low reset                      |
// |               load    - load preset, return to IDLE (highest priority)     |
// |               preset  - N+1 bit load value                                 |
// |               start   - begin countdown from IDLE                          |
// |               sub     - decrement request while running                    |
// |               pause   - freeze the count                                   |
// |               counter - registered count                                   |
// |               zero    - combinational counter == 0                         |
// |               done    - registered one-cycle terminal-count pulse          |
// |               alarm   - registered, high while in ALARM                    |
// |               state   - current FSM state encoding                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_CYC = HOLD_CYC_DEFAULT
) (
    input  logic         clk_N,
    input  logic         rst,
    input  logic         load,
    input  logic [N:0]   preset,
    input  logic         start,
    input  logic         sub,
    input  logic         pause,
    output logic [N:0]   counter,
    output logic         zero,
    output logic         done,
    output logic         alarm,
    output logic [1:0]   state
);

    localparam logic [N:0] c_one = (N+1)'(1);

    state_t     state_q,   state_d;
    logic [N:0] counter_q, counter_d;
    logic       done_q,    done_d;
    logic       alarm_q,   alarm_d;

    logic       hold_en;
    logic       hold_clr;
    logic       hold_expired;

    hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_timer (
        .clk_N    (clk_N),
        .rst      (rst),
        .enable   (hold_en),
        .clear    (hold_clr),
        .expired  (hold_expired)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        done_d    = 1'b0;
        hold_en   = 1'b0;
        hold_clr  = 1'b0;

        if (load) begin
            counter_d = preset;
            state_d   = ST_IDLE;
            hold_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A zero count has nothing to run down, so start is a no-op.
                    if (start && (counter_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (sub) begin
                        if (counter_q == c_one) begin
                            counter_d = '0;
                            done_d    = 1'b1;
                            state_d   = ST_ALARM;
                            hold_clr  = 1'b1;
                        end else if (counter_q != '0) begin
                            counter_d = counter_q - c_one;
                        end
                    end
                end
                ST_PAUSED: begin
                    // Resume without consuming a decrement on this edge.
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_ALARM: begin
                    hold_en = 1'b1;
                    if (hold_expired) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        alarm_d = (state_d == ST_ALARM);
    end

    always_ff @(negedge clk_N or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
        end
    end

    assign counter = counter_q;
    assign zero    = (counter_q == '0);
    assign done    = done_q;
    assign alarm   = alarm_q;
    assign state   = state_q;

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_countdown_timer                                           |
// | Description : Self-checking bench for countdown_timer. A behavioural       |
// |               model pushes expected outputs into a scoreboard queue as     |
// |               each input vector is driven; entries are popped and compared |
// |               after the falling edge.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_countdown_timer;

    localparam int N        = 4;
    localparam int HOLD_CYC = 8;

    typedef struct {
        logic [N:0] cnt;
        logic       zero;
        logic       done;
        logic       alarm;
        logic [1:0] st;
    } exp_t;

    logic         clk_N;
    logic         rst;
    logic         load;
    logic [N:0]   preset;
    logic         start;
    logic         sub;
    logic         pause;
    logic [N:0]   counter;
    logic         zero;
    logic         done;
    logic         alarm;
    logic [1:0]   state;

    exp_t sb_q[$];

    int n_checks;
    int n_pass;
    int done_seen;
    int alarm_seen;

    // Behavioural model state
    int m_cnt;
    int m_st;
    int m_done;
    int m_hold;

    countdown_timer #(
        .N        (N),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk_N   (clk_N),
        .rst     (rst),
        .load    (load),
        .preset  (preset),
        .start   (start),
        .sub     (sub),
        .pause   (pause),
        .counter (counter),
        .zero    (zero),
        .done    (done),
        .alarm   (alarm),
        .state   (state)
    );

    initial clk_N = 1'b1;
    always #5 clk_N = ~clk_N;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_st   = 0;
        m_done = 0;
        m_hold = 0;
    endtask

    // Advance the model by one falling edge and push the expected outputs.
    task automatic model_push(input logic l, input int p, input logic s,
                              input logic d, input logic pz);
        exp_t e;
        m_done = 0;
        if (l) begin
            m_cnt  = p;
            m_st   = 0;
            m_hold = 0;
        end else if (m_st == 0) begin
            if (s && m_cnt > 0) m_st = 1;
        end else if (m_st == 1) begin
            if (pz) begin
                m_st = 2;
            end else if (d && m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done = 1;
                    m_st   = 3;
                    m_hold = 0;
                end
            end
        end else if (m_st == 2) begin
            if (!pz) m_st = 1;
        end else begin
            m_hold = m_hold + 1;
            if (m_hold == HOLD_CYC) begin
                m_st   = 0;
                m_hold = 0;
            end
        end
        e.cnt   = (N+1)'(m_cnt);
        e.zero  = (m_cnt == 0);
        e.done  = (m_done != 0);
        e.alarm = (m_st == 3);
        e.st    = 2'(m_st);
        sb_q.push_back(e);
    endtask

    // One clock: drive inputs mid-cycle, predict, then compare after the edge.
    task automatic step(input string tag, input logic l, input int p,
                        input logic s, input logic d, input logic pz);
        exp_t e;
        @(posedge clk_N);
        load   = l;
        preset = (N+1)'(p);
        start  = s;
        sub    = d;
        pause  = pz;
        model_push(l, p, s, d, pz);
        @(negedge clk_N);
        #1;
        if (done)  done_seen++;
        if (alarm) alarm_seen++;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_counter"}, int'(counter), int'(e.cnt));
            check({tag, "_zero"},    int'(zero),    int'(e.zero));
            check({tag, "_done"},    int'(done),    int'(e.done));
            check({tag, "_alarm"},   int'(alarm),   int'(e.alarm));
            check({tag, "_state"},   int'(state),   int'(e.st));
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_rst_counter"}, int'(counter), 0);
        check({tag, "_rst_state"},   int'(state),   0);
        check({tag, "_rst_done"},    int'(done),    0);
        check({tag, "_rst_alarm"},   int'(alarm),   0);
        model_reset();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        load     = 1'b0;
        preset   = '0;
        start    = 1'b0;
        sub      = 1'b0;
        pause    = 1'b0;
        model_reset();

        // Reset state, before any clock edge
        #1;
        check("reset_counter", int'(counter), 0);
        check("reset_state",   int'(state),   0);
        check("reset_done",    int'(done),    0);
        check("reset_alarm",   int'(alarm),   0);
        check("reset_zero",    int'(zero),    1);
        #1;
        rst = 1'b1;

        // First edge after reset is plain IDLE; sub is ignored
        step("post_rst", 0, 0, 0, 1, 0);

        // preset=5, start, five decrements -> 4,3,2,1,0 and ALARM
        step("ld5", 1, 5, 0, 0, 0);
        step("st5", 0, 0, 1, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step("dec5", 0, 0, 0, 1, 0);
            check("dec5_seq", int'(counter), 4 - i);
            check("dec5_done_edge", int'(done), (i == 4) ? 1 : 0);
        end
        check("dec5_in_alarm", int'(state), 3);
        alarm_seen = 1;

        // Alarm hold: start/sub ignored, exits after HOLD_CYC edges
        for (int i = 0; i < HOLD_CYC; i++) begin
            step("hold", 0, 0, 1, 1, 0);
        end
        check("hold_alarm_cycles", alarm_seen, HOLD_CYC);
        check("hold_end_state", int'(state), 0);
        check("hold_end_zero", int'(zero), 1);
        check("hold_done_count", done_seen, 1);

        // Pause freezes the count even with sub held; resume costs no decrement
        step("ld3", 1, 3, 0, 0, 0);
        step("st3", 0, 0, 1, 0, 0);
        step("dec3", 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step("paused", 0, 0, 0, 1, 1);
        end
        check("paused_cnt", int'(counter), 2);
        check("paused_state", int'(state), 2);
        step("resume", 0, 0, 0, 1, 0);
        check("resume_cnt", int'(counter), 2);
        step("after_resume", 0, 0, 0, 1, 0);
        check("after_resume_cnt", int'(counter), 1);

        // preset=0: start cannot leave IDLE, no done
        step("ld0", 1, 0, 0, 0, 0);
        step("st0", 0, 0, 1, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step("zero_sub", 0, 0, 1, 1, 0);
        end
        check("zero_state", int'(state), 0);
        check("zero_done_count", done_seen, 0);

        // Reset mid-RUN at counter=2
        step("ld5b", 1, 5, 0, 0, 0);
        step("st5b", 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("run3", 0, 0, 0, 1, 0);
        check("run_at2", int'(counter), 2);
        done_seen = 0;
        async_reset("midrun");
        step("midrun_after", 0, 0, 1, 1, 0);
        step("midrun_after2", 0, 0, 0, 1, 0);
        check("midrun_no_done", done_seen, 0);

        // Load during ALARM on its 3rd edge, then a full second countdown
        step("ld5c", 1, 5, 0, 0, 0);
        step("st5c", 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("dec5c", 0, 0, 0, 1, 0);
        step("alarm_e1", 0, 0, 0, 0, 0);
        step("alarm_e2", 0, 0, 0, 0, 0);
        step("alarm_ld7", 1, 7, 0, 0, 0);
        check("ld7_state", int'(state), 0);
        check("ld7_alarm", int'(alarm), 0);
        check("ld7_cnt", int'(counter), 7);
        step("st7", 0, 0, 1, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 7; i++) step("dec7", 0, 0, 0, 1, 0);
        check("dec7_done_count", done_seen, 1);
        check("dec7_state", int'(state), 3);

        // Reset mid-ALARM
        step("alarm_mid", 0, 0, 0, 0, 0);
        async_reset("midalarm");
        step("midalarm_after", 0, 0, 0, 0, 0);

        // Random traffic, load kept rare so countdowns complete
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, (1 << (N+1)) - 1)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_countdown_timer
`default_nettype wire
